ts_par2ser: RTL and testbench

Parametrised transport-stream parallel-to-serial converter with input buffering. Accepts a parallel TS interface of DATA_W bits (1, 2 or 4 bytes per word) under a valid/ready handshake and emits a serial TS interface, MSB first, one bit per clock. Successor to the fixed-width parallel and serial TS interface definitions. Sits between a parallel TS source (demux or packet generator) and a serial TS output port, all in the system clock domain.

---
 rtl/ts_par2ser.sv | 172 +++++++++++++++++
 tb/tb_ts_par2ser.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ts_par2ser.sv
// Parallel-to-serial TS converter: DATA_W-bit words are buffered in a DEPTH-word FIFO and sent
// MSB first, one bit per clock. Define TS_PAR2SER_SYNC_CHECK_EN to enable the sync-byte check.
module ts_par2ser #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [DATA_W-1:0]        ts_par_data_i,
  input  logic                     ts_par_sync_i,
  input  logic                     ts_par_valid_i,
  output logic                     ts_par_ready_o,
  output logic                     ts_ser_data_o,
  output logic                     ts_ser_sync_o,
  output logic                     ts_ser_valid_o,
  output logic [$clog2(DEPTH):0]   fill_o,
  output logic                     sync_err_o
);

  localparam int unsigned AW  = $clog2(DEPTH);
  localparam int unsigned FW  = AW + 1;
  localparam int unsigned CW  = $clog2(DATA_W);
  localparam int unsigned CW1 = CW + 1;
  localparam logic [FW-1:0]  FillMax  = FW'(DEPTH);
  localparam logic [CW-1:0]  CntLast  = CW'(DATA_W - 1);
  localparam logic [CW1-1:0] SyncBits = CW1'(8);

  typedef enum logic {StIdle, StShift} state_e;

  logic [DATA_W:0]   mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [FW-1:0]     fill_q, fill_d;
  logic              push, pop, accept, fifo_empty;
  logic [DATA_W:0]   head;

  state_e            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [DATA_W-1:0] sh_data_q, sh_data_d;
  logic              sh_sync_q, sh_sync_d;
  logic              ser_data_q, ser_data_d;
  logic              ser_sync_q, ser_sync_d;
  logic              ser_valid_q, ser_valid_d;

  assign accept         = ts_par_valid_i & ts_par_ready_o;
  assign ts_par_ready_o = (fill_q != FillMax);
  assign fifo_empty     = (fill_q == '0);
  assign head           = mem_q[rd_ptr_q];

`ifdef TS_PAR2SER_SYNC_CHECK_EN
  logic drop_q, drop_d, sync_bad;
  logic sync_err_q, sync_err_d;

  // A bad sync word enters drop state; only a good sync word is written and leaves it.
  always_comb begin
    sync_bad   = ts_par_sync_i && (ts_par_data_i[DATA_W-1 -: 8] != 8'h47);
    push       = accept && !sync_bad && (!drop_q || ts_par_sync_i);
    drop_d     = drop_q;
    sync_err_d = 1'b0;
    if (accept && ts_par_sync_i) begin
      drop_d     = sync_bad;
      sync_err_d = sync_bad;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      drop_q     <= 1'b0;
      sync_err_q <= 1'b0;
    end else begin
      drop_q     <= drop_d;
      sync_err_q <= sync_err_d;
    end
  end

  assign sync_err_o = sync_err_q;
`else
  assign push       = accept;
  assign sync_err_o = 1'b0;
`endif

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    fill_d   = fill_q;
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    unique case ({push, pop})
      2'b10:   fill_d = fill_q + 1'b1;
      2'b01:   fill_d = fill_q - 1'b1;
      default: fill_d = fill_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {ts_par_sync_i, ts_par_data_i};
  end

  // Shifter reloads on the edge that emits the last bit, so back-to-back words have no bubble.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    sh_data_d   = sh_data_q;
    sh_sync_d   = sh_sync_q;
    ser_data_d  = 1'b0;
    ser_sync_d  = 1'b0;
    ser_valid_d = 1'b0;
    pop         = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (!fifo_empty) begin
          pop       = 1'b1;
          sh_data_d = head[DATA_W-1:0];
          sh_sync_d = head[DATA_W];
          cnt_d     = '0;
          state_d   = StShift;
        end
      end
      StShift: begin
        ser_valid_d = 1'b1;
        ser_data_d  = sh_data_q[DATA_W-1];
        ser_sync_d  = sh_sync_q && ({1'b0, cnt_q} < SyncBits);
        sh_data_d   = sh_data_q << 1;
        if (cnt_q == CntLast) begin
          cnt_d = '0;
          if (!fifo_empty) begin
            pop       = 1'b1;
            sh_data_d = head[DATA_W-1:0];
            sh_sync_d = head[DATA_W];
          end else begin
            state_d = StIdle;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      fill_q      <= '0;
      state_q     <= StIdle;
      cnt_q       <= '0;
      sh_data_q   <= '0;
      sh_sync_q   <= 1'b0;
      ser_data_q  <= 1'b0;
      ser_sync_q  <= 1'b0;
      ser_valid_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      fill_q      <= fill_d;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      sh_data_q   <= sh_data_d;
      sh_sync_q   <= sh_sync_d;
      ser_data_q  <= ser_data_d;
      ser_sync_q  <= ser_sync_d;
      ser_valid_q <= ser_valid_d;
    end
  end

  assign ts_ser_data_o  = ser_data_q;
  assign ts_ser_sync_o  = ser_sync_q;
  assign ts_ser_valid_o = ser_valid_q;
  assign fill_o         = fill_q;

endmodule

// File: tb/tb_ts_par2ser.sv
// Bench for ts_par2ser: an 8-bit instance checked by a bit-queue scoreboard plus directed vectors,
// and a 32-bit instance for the back-to-back wide-word case.
module tb_ts_par2ser;

  localparam int unsigned DW = 8;

  typedef struct {
    logic [7:0] data;
    logic       sync;
    logic [7:0] exp_bits;
    logic [7:0] exp_sync;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] par_data = '0;
  logic       par_sync = 1'b0, par_valid = 1'b0;
  logic       ready, ser_data, ser_sync, ser_valid, sync_err;
  logic [2:0] fill;

  logic [31:0] p32_data = '0;
  logic        p32_sync = 1'b0, p32_valid = 1'b0;
  logic        r32, s32_data, s32_sync, s32_valid, e32;
  logic [2:0]  f32;

  always #5 clk = ~clk;

  ts_par2ser #(.DATA_W(8), .DEPTH(4)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .ts_par_data_i(par_data), .ts_par_sync_i(par_sync), .ts_par_valid_i(par_valid),
    .ts_par_ready_o(ready),
    .ts_ser_data_o(ser_data), .ts_ser_sync_o(ser_sync), .ts_ser_valid_o(ser_valid),
    .fill_o(fill), .sync_err_o(sync_err)
  );

  ts_par2ser #(.DATA_W(32), .DEPTH(4)) u_dut32 (
    .clk(clk), .rst_n(rst_n),
    .ts_par_data_i(p32_data), .ts_par_sync_i(p32_sync), .ts_par_valid_i(p32_valid),
    .ts_par_ready_o(r32),
    .ts_ser_data_o(s32_data), .ts_ser_sync_o(s32_sync), .ts_ser_valid_o(s32_valid),
    .fill_o(f32), .sync_err_o(e32)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  // Reference model: each kept word becomes DW {sync, bit} entries, MSB first.
  bit         mon_en  = 1'b0;
  logic [1:0] exp_q[$];
  bit         drop_m  = 1'b0;
  bit         err_exp = 1'b0;
  int         acc_cnt = 0;

  task automatic model_accept(input logic [DW-1:0] d, input logic s);
    bit keep;
    keep = 1'b1;
`ifdef TS_PAR2SER_SYNC_CHECK_EN
    if (s) begin
      if (d[DW-1 -: 8] != 8'h47) begin
        drop_m  = 1'b1;
        err_exp = 1'b1;
        keep    = 1'b0;
      end else begin
        drop_m = 1'b0;
      end
    end else begin
      keep = !drop_m;
    end
`endif
    if (keep) begin
      for (int k = 0; k < int'(DW); k++) exp_q.push_back({s && (k < 8), d[DW-1-k]});
    end
  endtask

  always @(negedge clk) begin : mon
    logic [1:0] e;
    if (mon_en) begin
      if (ser_valid) begin
        chk("bit_pending", 64'(exp_q.size() != 0), 64'(1));
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("ser_bit", 64'({ser_sync, ser_data}), 64'(e));
        end
      end else begin
        chk("idle_outputs", 64'({ser_sync, ser_data}), 64'(0));
      end
      chk("sync_err", 64'(sync_err), 64'(err_exp));
      err_exp = 1'b0;
      if (!rst_n) begin
        exp_q.delete();
        drop_m = 1'b0;
      end else if (par_valid && ready) begin
        acc_cnt++;
        model_accept(par_data, par_sync);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  int vc, ec;
  task automatic stepc();
    step();
    if (ser_valid) vc++;
    if (sync_err) ec++;
  endtask

  vec_t        vecs[4];
  logic [7:0]  bits, syn;
  logic [63:0] b64, s64;
  logic [2:0]  maxf;
  int          vcnt, acc0, rh;
  logic        acc_now;

  initial begin
    vecs[0] = '{data: 8'h47, sync: 1'b1, exp_bits: 8'h47, exp_sync: 8'hFF};
    vecs[1] = '{data: 8'hA5, sync: 1'b0, exp_bits: 8'hA5, exp_sync: 8'h00};
    vecs[2] = '{data: 8'h01, sync: 1'b0, exp_bits: 8'h01, exp_sync: 8'h00};
    vecs[3] = '{data: 8'hFE, sync: 1'b0, exp_bits: 8'hFE, exp_sync: 8'h00};

    rst_n = 1'b0;
    repeat (3) step();
    chk("rst_ready", 64'(ready), 64'(1));
    chk("rst_data", 64'(ser_data), 64'(0));
    chk("rst_sync", 64'(ser_sync), 64'(0));
    chk("rst_valid", 64'(ser_valid), 64'(0));
    chk("rst_fill", 64'(fill), 64'(0));
    chk("rst_err", 64'(sync_err), 64'(0));
    chk("rst_ready32", 64'(r32), 64'(1));
    chk("rst_fill32", 64'(f32), 64'(0));
    rst_n  = 1'b1;
    mon_en = 1'b1;
    step();

    // Single words into an idle block: exact latency and bit order.
    for (int i = 0; i < 4; i++) begin
      par_data  = vecs[i].data;
      par_sync  = vecs[i].sync;
      par_valid = 1'b1;
      step();
      par_valid = 1'b0;
      par_sync  = 1'b0;
      step();
      chk("vec_latency_idle", 64'(ser_valid), 64'(0));
      bits = '0;
      syn  = '0;
      vcnt = 0;
      for (int k = 0; k < 8; k++) begin
        step();
        bits = {bits[6:0], ser_data};
        syn  = {syn[6:0], ser_sync};
        if (ser_valid) vcnt++;
      end
      chk("vec_bits", 64'(bits), 64'(vecs[i].exp_bits));
      chk("vec_sync", 64'(syn), 64'(vecs[i].exp_sync));
      chk("vec_valid_cnt", 64'(vcnt), 64'(8));
      step();
      chk("vec_tail_idle", 64'(ser_valid), 64'(0));
      repeat (2) step();
    end

    // Bad sync word, follower, then a good sync word.
    vc = 0;
    ec = 0;
    par_valid = 1'b1;
    par_data = 8'h00; par_sync = 1'b1; stepc();
    par_data = 8'h12; par_sync = 1'b0; stepc();
    par_data = 8'h47; par_sync = 1'b1; stepc();
    par_valid = 1'b0;
    par_sync  = 1'b0;
    repeat (35) stepc();
`ifdef TS_PAR2SER_SYNC_CHECK_EN
    chk("synchk_valid_bits", 64'(vc), 64'(8));
    chk("synchk_err_pulses", 64'(ec), 64'(1));
`else
    chk("synchk_valid_bits", 64'(vc), 64'(24));
    chk("synchk_err_pulses", 64'(ec), 64'(0));
`endif

    // Saturate the FIFO with incrementing data.
    par_valid = 1'b1;
    par_sync  = 1'b0;
    par_data  = 8'h00;
    maxf = '0;
    acc0 = 0;
    rh   = 0;
    for (int c = 0; c < 84; c++) begin
      acc_now = ready;
      if (c == 20) acc0 = acc_cnt;
      if (c >= 20 && ready) rh++;
      step();
      if (acc_now) par_data++;
      if (fill > maxf) maxf = fill;
    end
    par_valid = 1'b0;
    chk("full_max_fill", 64'(maxf), 64'(4));
    chk("full_accepts_per_64", 64'(acc_cnt - acc0), 64'(8));
    chk("full_ready_cycles", 64'(rh), 64'(8));
    repeat (50) step();
    chk("full_drained_queue", 64'(exp_q.size()), 64'(0));
    chk("full_drained_fill", 64'(fill), 64'(0));

    // Randomised traffic against the scoreboard.
    for (int c = 0; c < 500; c++) begin
      par_valid = ($urandom_range(0, 3) != 0);
      par_data  = 8'($urandom);
      par_sync  = ($urandom_range(0, 5) == 0);
      if (par_sync && $urandom_range(0, 3) != 0) par_data = 8'h47;
      step();
    end
    par_valid = 1'b0;
    par_sync  = 1'b0;
    repeat (60) step();
    chk("rand_drained_queue", 64'(exp_q.size()), 64'(0));

    // Reset while bit 3 of a word is on the output and two words are buffered.
    par_valid = 1'b1;
    par_data = 8'hC3; step();
    par_data = 8'h5A; step();
    par_data = 8'h96; step();
    par_valid = 1'b0;
    repeat (3) step();
    chk("midrst_bit3_valid", 64'(ser_valid), 64'(1));
    chk("midrst_bit3_data", 64'(ser_data), 64'(0));
    chk("midrst_fill", 64'(fill), 64'(2));
    rst_n = 1'b0;
    step();
    chk("midrst_ready", 64'(ready), 64'(1));
    chk("midrst_data", 64'(ser_data), 64'(0));
    chk("midrst_sync", 64'(ser_sync), 64'(0));
    chk("midrst_valid", 64'(ser_valid), 64'(0));
    chk("midrst_fill0", 64'(fill), 64'(0));
    chk("midrst_err", 64'(sync_err), 64'(0));
    rst_n = 1'b1;
    vc = 0;
    ec = 0;
    repeat (30) stepc();
    chk("midrst_no_residue", 64'(vc), 64'(0));

    // 32-bit words back to back: 64 contiguous bits.
    p32_valid = 1'b1;
    p32_data = 32'h471FFF10; p32_sync = 1'b1; step();
    p32_data = 32'hFEDCBA98; p32_sync = 1'b0; step();
    p32_valid = 1'b0;
    b64  = '0;
    s64  = '0;
    vcnt = 0;
    for (int k = 0; k < 64; k++) begin
      step();
      b64 = {b64[62:0], s32_data};
      s64 = {s64[62:0], s32_sync};
      if (s32_valid) vcnt++;
    end
    chk("w32_bits", b64, 64'h471FFF10FEDCBA98);
    chk("w32_sync", s64, 64'hFF00000000000000);
    chk("w32_valid_cnt", 64'(vcnt), 64'(64));
    step();
    chk("w32_tail_idle", 64'(s32_valid), 64'(0));
    chk("w32_err", 64'(e32), 64'(0));
    chk("w32_fill", 64'(f32), 64'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
